shifter_seq: RTL and testbench
==============================

// Module: shifter_seq
// PURPOSE
//  Multi-cycle, parametrised shift/rotate unit for the datapath. It replaces the fixed 16-bit, 1-bit
//  combinational shifter. Takes an operand, a shift amount and an op under a start/done handshake,
//  then shifts up to STEP bits per clock. Reports the result plus the last bit shifted out
//  (carry_out) for the status logic.
// PARAMETERS
//  WIDTH  16               operand/result width in bits (>=2)
//  AMT_W  $clog2(WIDTH)    width of shift_amt; legal amounts 0..WIDTH-1
//  STEP   1                max bits shifted per clock (1..WIDTH); elaboration error outside range
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled on clk rise, accepted only when busy==0
//  shift_in   in   WIDTH  operand, captured on accepted start
//  shift_amt  in   AMT_W  shift distance, captured on accepted start
//  shift_op   in   3      000 none, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 11x = none
//  busy       out  1      high while in SHIFT
//  done       out  1      one-cycle pulse: result valid
//  shift_out  out  WIDTH  result register; holds until the next accepted start
//  carry_out  out  1      last bit shifted out; held alongside shift_out
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n). rst_n=0 at any time, mid-operation
//    included: state=IDLE, busy=0, done=0, shift_out=0, carry_out=0, cnt=0. Any in-flight op is discarded.
//  - FSM states: IDLE, SHIFT, DONE. Outputs: busy=(state==SHIFT), done=(state==DONE).
//  - Accept (state IDLE or DONE, start=1):
//      - acc<=shift_in; op captured; cnt<=shift_amt.
//      - cnt<=0 instead if op is none/11x.
//      - carry_out<=0.
//      - Next state: DONE if the loaded cnt==0, else SHIFT.
//  - SHIFT, each edge:
//      - s=min(STEP,cnt); acc shifted by s; cnt<=cnt-s.
//      - Next state: DONE when cnt-s==0, else SHIFT.
//      - start is ignored while busy.
//  - DONE lasts exactly one cycle. Next state: IDLE, or a new accept if start=1 that cycle
//    (back-to-back supported, done then pulses again later).
//  - Latency: done asserted 1+ceil(amt/STEP) edges after the accepting edge counts as edge 1;
//    amt=0 or op none gives done in the cycle right after acceptance.
//  - shift_out tracks acc and is only meaningful when done=1 or after done while IDLE.
//    Intermediate values are visible during SHIFT.
//  - Fill rules:
//      - LSL fills zeros at LSB.
//      - LSR fills zeros at MSB.
//      - ASR replicates the captured MSB.
//      - ROL/ROR wrap bits around.
//  - carry_out is updated on the final shift edge; the final result is independent of STEP:
//      - LSL: shift_in[WIDTH-amt].
//      - LSR/ASR: shift_in[amt-1].
//      - ROL: result[0].
//      - ROR: result[WIDTH-1].
//      - amt=0 or none: 0.
//  - Inputs are not required to be stable after the accepting edge.
// TESTING (WIDTH=16 unless noted)
//  T1 STEP=1, shift_in=16'hF0CF, op=000, amt=5, start
//      -> done next cycle, shift_out=16'hF0CF, carry_out=0, busy never high.
//  T2 STEP=1, shift_in=16'hF0CF, amt=1
//      -> LSL: 16'hE19E carry 1.
//      -> LSR: 16'h7867 carry 1.
//      -> ASR: 16'hF867 carry 1.
//      -> each: done 2 edges after accept.
//  T3 STEP=1, ASR shift_in=16'hC000, amt=4
//      -> busy 4 cycles, done on 5th, shift_out=16'hFC00, carry_out=0.
//  T4 STEP=4, ROR shift_in=16'hF0CF, amt=5
//      -> done 3 edges after accept, shift_out=16'h7F86, carry_out=0.
//  T4 STEP=4, ROL shift_in=16'hF0CF, amt=8
//      -> shift_out=16'hCFF0, carry_out=0.
//  T5 start pulsed during busy with different operand
//      -> ignored, original result unchanged.
//  T5 start held in the DONE cycle
//      -> second op accepted, done pulses again.
//  T6 rst_n low mid-SHIFT
//      -> outputs 0 immediately, without a clock edge.
//  T6 after release, new start
//      -> correct result.

Source files
------------

// File: rtl/shifter_seq_if.sv
// Handshake and data bundle between a shifter_seq unit and the datapath that drives it.
// The master side issues start/operand/amount/op and observes busy/done/result/carry.
interface shifter_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             start_i;
  logic [WIDTH-1:0] shift_in_i;
  logic [AMT_W-1:0] shift_amt_i;
  logic [2:0]       shift_op_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] shift_out_o;
  logic             carry_out_o;

  modport master (
    output start_i, shift_in_i, shift_amt_i, shift_op_i,
    input  busy_o, done_o, shift_out_o, carry_out_o
  );

  modport slave (
    input  start_i, shift_in_i, shift_amt_i, shift_op_i,
    output busy_o, done_o, shift_out_o, carry_out_o
  );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bits per clock under a start/done handshake
// and reports the last bit shifted out as carry.
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int STEP  = 1
) (
  input logic        clk,
  input logic        rst_n,
  shifter_seq_if.slave bus
);

  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("shifter_seq: STEP must be in 1..WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("shifter_seq: WIDTH must be at least 2");
  end

  localparam int            CW     = AMT_W + 1;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic               accept;
  logic               opIsShift;
  logic [CW-1:0]      cntExt;
  logic [CW-1:0]      stepAmt;
  logic [WIDTH:0]     lslWide, lsrWide, asrWide;
  logic [2*WIDTH-1:0] rolWide, rorWide;
  logic [WIDTH-1:0]   shifted;
  logic               shiftCarry;

  // Each shift is done one bit wider than the operand so the extra bit catches the
  // last bit pushed out; rotates use a doubled operand so the wrap falls out naturally.
  always_comb begin
    cntExt     = {1'b0, cnt_q};
    stepAmt    = (cntExt < STEP_C) ? cntExt : STEP_C;
    lslWide    = {1'b0, acc_q} << stepAmt;
    lsrWide    = {acc_q, 1'b0} >> stepAmt;
    asrWide    = $signed({acc_q, 1'b0}) >>> stepAmt;
    rolWide    = {acc_q, acc_q} << stepAmt;
    rorWide    = {acc_q, acc_q} >> stepAmt;
    shifted    = acc_q;
    shiftCarry = carry_q;
    case (op_q)
      OP_LSL: begin
        shifted    = lslWide[WIDTH-1:0];
        shiftCarry = lslWide[WIDTH];
      end
      OP_LSR: begin
        shifted    = lsrWide[WIDTH:1];
        shiftCarry = lsrWide[0];
      end
      OP_ASR: begin
        shifted    = asrWide[WIDTH:1];
        shiftCarry = asrWide[0];
      end
      OP_ROL: begin
        shifted    = rolWide[2*WIDTH-1:WIDTH];
        shiftCarry = rolWide[WIDTH];
      end
      OP_ROR: begin
        shifted    = rorWide[WIDTH-1:0];
        shiftCarry = rorWide[WIDTH-1];
      end
      default: begin
        shifted    = acc_q;
        shiftCarry = carry_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    accept    = bus.start_i && (state_q != SHIFT);
    opIsShift = (bus.shift_op_i != 3'b000) && (bus.shift_op_i[2:1] != 2'b11);
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          acc_d   = bus.shift_in_i;
          op_d    = bus.shift_op_i;
          carry_d = 1'b0;
          cnt_d   = opIsShift ? bus.shift_amt_i : '0;
          state_d = (cnt_d == '0) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d   = shifted;
        carry_d = shiftCarry;
        cnt_d   = cnt_q - stepAmt[AMT_W-1:0];
        state_d = (cnt_d == '0) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy_o      = (state_q == SHIFT);
  assign bus.done_o      = (state_q == DONE);
  assign bus.shift_out_o = acc_q;
  assign bus.carry_out_o = carry_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Scoreboard bench for shifter_seq: one unit with STEP=1 and one with STEP=4, each checked
// against a bit-serial reference model for result, carry, done latency and busy duration.
module tb_shifter_seq;
  localparam int W  = 16;
  localparam int AW = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    int           doneCycle;
    int           busyCycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  exp_t         q1[$];
  exp_t         q4[$];
  int           busyCnt1 = 0;
  int           busyCnt4 = 0;
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last4 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  shifter_seq_if #(.WIDTH(W), .AMT_W(AW)) bus1 ();
  shifter_seq_if #(.WIDTH(W), .AMT_W(AW)) bus4 ();

  shifter_seq #(.WIDTH(W), .AMT_W(AW), .STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  shifter_seq #(.WIDTH(W), .AMT_W(AW), .STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference: shift one bit at a time, remembering the bit that falls off.
  function automatic void refShift(input logic [2:0] op, input logic [W-1:0] din, input int amt,
                                   output logic [W-1:0] res, output logic carry);
    res   = din;
    carry = 1'b0;
    if (op == 3'b000 || op[2:1] == 2'b11) return;
    for (int i = 0; i < amt; i++) begin
      case (op)
        3'b001: begin carry = res[W-1]; res = {res[W-2:0], 1'b0}; end
        3'b010: begin carry = res[0]; res = {1'b0, res[W-1:1]}; end
        3'b011: begin carry = res[0]; res = {res[W-1], res[W-1:1]}; end
        3'b100: begin res = {res[W-2:0], res[W-1]}; carry = res[0]; end
        default: begin res = {res[0], res[W-1:1]}; carry = res[W-1]; end
      endcase
    end
  endfunction

  function automatic int expLatency(input logic [2:0] op, input int amt, input int step);
    if (op == 3'b000 || op[2:1] == 2'b11 || amt == 0) return 1;
    return 1 + (amt + step - 1) / step;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one request; inputs are scrambled afterwards since the unit must not depend on them.
  task automatic applyStimulus(input int sel, input logic [2:0] op, input logic [W-1:0] din,
                               input logic [AW-1:0] amt, input bit accepted);
    exp_t e;
    int   step;
    int   lat;
    step = (sel == 1) ? 1 : 4;
    lat  = expLatency(op, int'(amt), step);
    refShift(op, din, int'(amt), e.res, e.carry);
    e.doneCycle  = cycle + lat;
    e.busyCycles = lat - 1;
    if (sel == 1) begin
      bus1.start_i = 1'b1; bus1.shift_op_i = op; bus1.shift_in_i = din; bus1.shift_amt_i = amt;
      if (accepted) q1.push_back(e);
    end else begin
      bus4.start_i = 1'b1; bus4.shift_op_i = op; bus4.shift_in_i = din; bus4.shift_amt_i = amt;
      if (accepted) q4.push_back(e);
    end
    tick();
    if (sel == 1) begin
      bus1.start_i = 1'b0; bus1.shift_in_i = ~din; bus1.shift_amt_i = AW'($urandom);
      bus1.shift_op_i = 3'($urandom);
    end else begin
      bus4.start_i = 1'b0; bus4.shift_in_i = ~din; bus4.shift_amt_i = AW'($urandom);
      bus4.shift_op_i = 3'($urandom);
    end
  endtask

  task automatic waitIdle(input int sel);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sel == 1) idle = (q1.size() == 0) && !bus1.busy_o && !bus1.done_o;
      else          idle = (q4.size() == 0) && !bus4.busy_o && !bus4.done_o;
      if (idle) break;
      tick();
    end
    if (sel == 1) begin
      checkOutput("dut1_idle", 32'(idle), 32'd1);
      checkOutput("dut1_hold", 32'(bus1.shift_out_o), 32'(last1));
    end else begin
      checkOutput("dut4_idle", 32'(idle), 32'd1);
      checkOutput("dut4_hold", 32'(bus4.shift_out_o), 32'(last4));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyCnt1 = 0;
      last1    = '0;
    end else begin
      if (bus1.busy_o) busyCnt1++;
      if (bus1.done_o) begin
        checkOutput("dut1_done_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          checkOutput("dut1_result", 32'(bus1.shift_out_o), 32'(e.res));
          checkOutput("dut1_carry", 32'(bus1.carry_out_o), 32'(e.carry));
          checkOutput("dut1_latency", 32'(cycle), 32'(e.doneCycle));
          checkOutput("dut1_busy_cycles", 32'(busyCnt1), 32'(e.busyCycles));
          last1 = e.res;
        end
        busyCnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyCnt4 = 0;
      last4    = '0;
    end else begin
      if (bus4.busy_o) busyCnt4++;
      if (bus4.done_o) begin
        checkOutput("dut4_done_expected", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          checkOutput("dut4_result", 32'(bus4.shift_out_o), 32'(e.res));
          checkOutput("dut4_carry", 32'(bus4.carry_out_o), 32'(e.carry));
          checkOutput("dut4_latency", 32'(cycle), 32'(e.doneCycle));
          checkOutput("dut4_busy_cycles", 32'(busyCnt4), 32'(e.busyCycles));
          last4 = e.res;
        end
        busyCnt4 = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus1.start_i = 1'b0; bus1.shift_in_i = '0; bus1.shift_amt_i = '0; bus1.shift_op_i = '0;
    bus4.start_i = 1'b0; bus4.shift_in_i = '0; bus4.shift_amt_i = '0; bus4.shift_op_i = '0;
    tick();
    tick();
    checkOutput("rst_dut1_busy", 32'(bus1.busy_o), 32'd0);
    checkOutput("rst_dut1_done", 32'(bus1.done_o), 32'd0);
    checkOutput("rst_dut1_out", 32'(bus1.shift_out_o), 32'd0);
    checkOutput("rst_dut1_carry", 32'(bus1.carry_out_o), 32'd0);
    checkOutput("rst_dut4_busy", 32'(bus4.busy_o), 32'd0);
    checkOutput("rst_dut4_out", 32'(bus4.shift_out_o), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed ops, STEP=1");
    applyStimulus(1, 3'b000, 16'hF0CF, 4'd5, 1'b1); waitIdle(1);
    applyStimulus(1, 3'b001, 16'hF0CF, 4'd1, 1'b1); waitIdle(1);
    applyStimulus(1, 3'b010, 16'hF0CF, 4'd1, 1'b1); waitIdle(1);
    applyStimulus(1, 3'b011, 16'hF0CF, 4'd1, 1'b1); waitIdle(1);
    applyStimulus(1, 3'b110, 16'h1234, 4'd7, 1'b1); waitIdle(1);
    applyStimulus(1, 3'b001, 16'h8001, 4'd15, 1'b1); waitIdle(1);

    $display("[TB] ASR with ignored start while busy");
    applyStimulus(1, 3'b011, 16'hC000, 4'd4, 1'b1);
    applyStimulus(1, 3'b001, 16'h1234, 4'd3, 1'b0);
    waitIdle(1);

    $display("[TB] directed ops, STEP=4");
    applyStimulus(4, 3'b101, 16'hF0CF, 4'd5, 1'b1); waitIdle(4);
    applyStimulus(4, 3'b100, 16'hF0CF, 4'd8, 1'b1); waitIdle(4);
    applyStimulus(4, 3'b011, 16'h8421, 4'd15, 1'b1); waitIdle(4);
    applyStimulus(4, 3'b010, 16'hBEEF, 4'd0, 1'b1); waitIdle(4);

    $display("[TB] back-to-back start in the done cycle");
    applyStimulus(1, 3'b001, 16'h00FF, 4'd3, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (bus1.done_o) break;
      tick();
    end
    checkOutput("b2b_done_seen", 32'(bus1.done_o), 32'd1);
    applyStimulus(1, 3'b101, 16'h0F0F, 4'd2, 1'b1);
    waitIdle(1);

    $display("[TB] asynchronous reset mid-shift");
    applyStimulus(1, 3'b100, 16'hA5A5, 4'd12, 1'b1);
    tick();
    tick();
    checkOutput("pre_reset_busy", 32'(bus1.busy_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(bus1.busy_o), 32'd0);
    checkOutput("async_rst_done", 32'(bus1.done_o), 32'd0);
    checkOutput("async_rst_out", 32'(bus1.shift_out_o), 32'd0);
    checkOutput("async_rst_carry", 32'(bus1.carry_out_o), 32'd0);
    q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1, 3'b101, 16'h8001, 4'd3, 1'b1);
    waitIdle(1);

    $display("[TB] random ops on both units");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      waitIdle(1);
      applyStimulus(4, 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      waitIdle(4);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
